melody_sequencer: RTL and testbench
===================================

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 The block SHALL have parameter BEAT_CLKS, default 5_000_000, giving clocks per beat (100 ms at 50 MHz).
REQ-002 The block SHALL have parameter GAP_CLKS, default 250_000, giving the silent clocks inserted after every note; it must be less than BEAT_CLKS.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port startMelody, input, 1 bit: one-clock request to start playing.
REQ-006 The block SHALL have port stopMelody, input, 1 bit: one-clock request to abort playback.
REQ-007 The block SHALL have port loopEn, input, 1 bit: when high, the melody restarts at note 0 instead of finishing.
REQ-008 The block SHALL have port melodyReq, input, 4 bits: the melody number, sampled on start.
REQ-009 The block SHALL have port toneIn, input, 4 bits: tone index from the sheet-music ROM.
REQ-010 The block SHALL have port lengthIn, input, 4 bits: note length in beats from the ROM; 0 marks end of melody.
REQ-011 The block SHALL have port silenceInN, input, 1 bit: low means the ROM note is a rest.
REQ-012 The block SHALL have port melodySelect, output, 4 bits: the latched melody number driven to the ROM.
REQ-013 The block SHALL have port noteIndex, output, 5 bits: the current note address driven to the ROM.
REQ-014 The block SHALL have port tone, output, 4 bits: the registered tone index driven to the tone decoder.
REQ-015 The block SHALL have port soundEnable, output, 1 bit: high while an audible note is sounding.
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 The block SHALL have port melodyDone, output, 1 bit: one-clock pulse when a melody ends or is stopped.

Function
REQ-018 The state machine SHALL have exactly the states IDLE, LOAD, PLAY, GAP and DONE.
REQ-019 In IDLE, startMelody SHALL latch melodyReq into melodySelect, clear noteIndex to 0 and move to LOAD on the next edge.
REQ-020 The block SHALL spend exactly one clock in LOAD, to let the combinational ROM settle on noteIndex.
REQ-021 At the end of LOAD the block SHALL register toneIn into tone, register lengthIn and silenceInN, and clear the clock and beat counters.
REQ-022 In LOAD, lengthIn = 0 SHALL go to DONE, or to LOAD with noteIndex = 0 when loopEn = 1; a nonzero length SHALL go to PLAY.
REQ-023 PLAY SHALL last exactly length x BEAT_CLKS clocks, counted as BEAT_CLKS clocks per beat and length beats.
REQ-024 soundEnable SHALL equal the registered silenceInN during PLAY and be 0 in every other state.
REQ-025 GAP SHALL last exactly GAP_CLKS clocks with soundEnable = 0.
REQ-026 At the end of GAP, if noteIndex < 31 the block SHALL increment noteIndex and go to LOAD.
REQ-027 At the end of GAP, if noteIndex = 31 the block SHALL go to DONE, or wrap noteIndex to 0 and go to LOAD when loopEn = 1; noteIndex never increments past 31.
REQ-028 DONE SHALL last one clock with melodyDone = 1, then go to IDLE; noteIndex and melodySelect hold their values.
REQ-029 stopMelody in LOAD, PLAY or GAP SHALL go to DONE on the next edge with soundEnable low from that edge onward.
REQ-030 If stopMelody and startMelody are high in the same clock, stop SHALL win.
REQ-031 startMelody in any state other than IDLE SHALL be ignored; a new start is accepted only once back in IDLE.
REQ-032 Latency: with startMelody high at edge t, the block SHALL be in LOAD after edge t+1 and soundEnable SHALL first rise after edge t+2.
REQ-033 The clock counter SHALL be sized clog2(BEAT_CLKS) and the beat counter 4 bits; neither SHALL wrap inside a note.

Reset
REQ-034 On reset assertion, asynchronously, the block SHALL enter IDLE with melodySelect = 0, noteIndex = 0, tone = silence (4'hF), soundEnable = 0, busy = 0, melodyDone = 0 and all counters at 0.
REQ-035 A reset during playback SHALL abort immediately, without a melodyDone pulse.

Structure
REQ-036 The musicNote enum, the SILENCE constant (4'hF) and MAX_NOTES = 32 SHALL live in the shared package audio_pkg.
REQ-037 The state enum SHALL be local to melody_sequencer.
REQ-038 Beat timing SHALL be one sub-module, beat_timer, with inputs clear and enable and outputs beatTick and gapDone.

Verification (BEAT_CLKS = 4, GAP_CLKS = 2, bench ROM model)
REQ-039 Bench SHALL drive melody {sol len 2, mi len 1, len 0} with a start pulse and check: soundEnable high 8 clocks with tone = 7, low 2, high 4 with tone = 4, low 2, then one melodyDone pulse and busy = 0.
REQ-040 Bench SHALL drive a rest note (silenceInN = 0) of len 3 and check soundEnable = 0 for all 12 PLAY clocks while noteIndex still advances.
REQ-041 Bench SHALL drive a 32-note ROM with no len 0 entry and check DONE after note 31 with noteIndex = 31; then repeat with loopEn = 1 and check noteIndex wraps to 0 with busy held high.
REQ-042 Bench SHALL pulse stopMelody mid-PLAY on note 2 and check soundEnable = 0 and melodyDone = 1 on the next clock, then IDLE.
REQ-043 Bench SHALL pulse startMelody during GAP with melodyReq = 5 and check melodySelect is unchanged; a simultaneous start and stop SHALL end in DONE.
REQ-044 Bench SHALL assert reset mid-PLAY and check all outputs reach their reset values without waiting for a clock edge, with no melodyDone pulse.

Source files
------------

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared audio definitions for the melody player: the musical note encoding
// used by the sheet-music ROM and the tone decoder, the silence code, and the
// maximum melody length in notes.
// Ports: none (package).
// -----------------------------------------------------------------------------
package audio_pkg;

  // Tone index reserved for "no tone"; the tone decoder mutes on this value.
  localparam logic [3:0] SILENCE = 4'hF;

  // A melody holds at most this many notes; noteIndex addresses 0..MAX_NOTES-1.
  localparam int MAX_NOTES = 32;

  localparam logic [4:0] LAST_NOTE = 5'(MAX_NOTES - 1);

  // Chromatic scale starting at DO, as stored in the sheet-music ROM.
  typedef enum logic [3:0] {
    NOTE_DO    = 4'd0,
    NOTE_DO_S  = 4'd1,
    NOTE_RE    = 4'd2,
    NOTE_RE_S  = 4'd3,
    NOTE_MI    = 4'd4,
    NOTE_FA    = 4'd5,
    NOTE_FA_S  = 4'd6,
    NOTE_SOL   = 4'd7,
    NOTE_SOL_S = 4'd8,
    NOTE_LA    = 4'd9,
    NOTE_LA_S  = 4'd10,
    NOTE_SI    = 4'd11,
    NOTE_DO_HI = 4'd12,
    NOTE_REST  = 4'hF
  } musicNote;

  // True when idx addresses the final ROM slot of a melody.
  function automatic logic is_last_note(input logic [4:0] idx);
    return (idx == LAST_NOTE);
  endfunction

endpackage

// File: rtl/beat_timer.sv
// -----------------------------------------------------------------------------
// beat_timer
// Clock counter that paces note playback. While enabled it counts clocks and
// wraps every BEAT_CLKS clocks, flagging the last clock of each beat. The same
// counter measures the inter-note gap: the gap always starts right after a
// beat wrap, so the count restarts at zero and gapDone flags its last clock.
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-high reset
//   clear    - synchronous clear of the counter
//   enable   - count this clock
//   beatTick - last clock of a beat (combinational)
//   gapDone  - last clock of the gap window (combinational)
// -----------------------------------------------------------------------------
module beat_timer #(
  parameter int BEAT_CLKS = 5_000_000,
  parameter int GAP_CLKS  = 250_000,
  localparam int CW = (BEAT_CLKS > 1) ? $clog2(BEAT_CLKS) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic beatTick,
  output logic gapDone
);

  localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_CLKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CLKS - 1);

  logic [CW-1:0] clk_cnt;

  // Clock counter: wraps at the end of each beat so it never overflows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_cnt <= {CW{1'b0}};
    end else if (clear) begin
      clk_cnt <= {CW{1'b0}};
    end else if (enable) begin
      if (clk_cnt == BEAT_LAST) begin
        clk_cnt <= {CW{1'b0}};
      end else begin
        clk_cnt <= clk_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      clk_cnt <= clk_cnt;
    end
  end

  assign beatTick = enable && !clear && (clk_cnt == BEAT_LAST);
  assign gapDone  = enable && !clear && (clk_cnt == GAP_LAST);

endmodule

// File: rtl/melody_sequencer.sv
// -----------------------------------------------------------------------------
// melody_sequencer
// Walks the sheet-music ROM note by note. Each note is fetched (LOAD), played
// for length beats (PLAY), then followed by a short silence (GAP). A zero
// length or the last ROM slot ends the melody (DONE) unless looping is on.
// Ports:
//   clk, reset    - system clock, asynchronous active-high reset
//   startMelody   - one-clock start request, honoured only in IDLE
//   stopMelody    - one-clock abort request, wins over startMelody
//   loopEn        - restart at note 0 instead of finishing
//   melodyReq     - melody number latched on start
//   toneIn        - ROM tone index for noteIndex
//   lengthIn      - ROM note length in beats, 0 = end of melody
//   silenceInN    - ROM flag, low = rest
//   melodySelect  - latched melody number to the ROM
//   noteIndex     - current note address to the ROM
//   tone          - registered tone index to the tone decoder
//   soundEnable   - high while an audible note sounds
//   busy          - high outside IDLE
//   melodyDone    - one-clock pulse when the melody ends or is stopped
// -----------------------------------------------------------------------------
module melody_sequencer
  import audio_pkg::*;
#(
  parameter int BEAT_CLKS = 5_000_000,
  parameter int GAP_CLKS  = 250_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startMelody,
  input  logic       stopMelody,
  input  logic       loopEn,
  input  logic [3:0] melodyReq,
  input  logic [3:0] toneIn,
  input  logic [3:0] lengthIn,
  input  logic       silenceInN,
  output logic [3:0] melodySelect,
  output logic [4:0] noteIndex,
  output logic [3:0] tone,
  output logic       soundEnable,
  output logic       busy,
  output logic       melodyDone
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PLAY = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t     state, state_next;
  logic [3:0] sel_next;
  logic [4:0] note_next;
  logic [3:0] tone_next;
  logic [3:0] len_reg, len_next;
  logic       silence_reg, silence_next;
  logic [3:0] beat_cnt, beat_next;
  logic       sound_next, busy_next, done_next;
  logic       timer_clear, timer_enable;
  logic       beat_tick, gap_done;

  // The timer runs only while a note or its gap is timing; otherwise held at 0.
  assign timer_enable = (state == PLAY) || (state == GAP);
  assign timer_clear  = !timer_enable;

  beat_timer #(
    .BEAT_CLKS (BEAT_CLKS),
    .GAP_CLKS  (GAP_CLKS)
  ) u_beat_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .enable   (timer_enable),
    .beatTick (beat_tick),
    .gapDone  (gap_done)
  );

  // Next-state and next-output logic; outputs are computed from the next state
  // so every output port comes straight from a flop.
  always_comb begin
    state_next   = state;
    sel_next     = melodySelect;
    note_next    = noteIndex;
    tone_next    = tone;
    len_next     = len_reg;
    silence_next = silence_reg;
    beat_next    = beat_cnt;

    case (state)
      IDLE: begin
        if (startMelody && !stopMelody) begin
          sel_next   = melodyReq;
          note_next  = 5'd0;
          state_next = LOAD;
        end else begin
          state_next = IDLE;
        end
      end

      LOAD: begin
        if (stopMelody) begin
          state_next = DONE;
        end else begin
          tone_next    = toneIn;
          len_next     = lengthIn;
          silence_next = silenceInN;
          beat_next    = 4'd0;
          if (lengthIn == 4'd0) begin
            if (loopEn) begin
              note_next  = 5'd0;
              state_next = LOAD;
            end else begin
              state_next = DONE;
            end
          end else begin
            state_next = PLAY;
          end
        end
      end

      PLAY: begin
        if (stopMelody) begin
          state_next = DONE;
        end else if (beat_tick) begin
          // len_reg is never 0 here: a zero length never leaves LOAD for PLAY.
          if (beat_cnt == (len_reg - 4'd1)) begin
            beat_next  = 4'd0;
            state_next = GAP;
          end else begin
            beat_next  = beat_cnt + 4'd1;
            state_next = PLAY;
          end
        end else begin
          state_next = PLAY;
        end
      end

      GAP: begin
        if (stopMelody) begin
          state_next = DONE;
        end else if (gap_done) begin
          if (!is_last_note(noteIndex)) begin
            note_next  = noteIndex + 5'd1;
            state_next = LOAD;
          end else if (loopEn) begin
            note_next  = 5'd0;
            state_next = LOAD;
          end else begin
            state_next = DONE;
          end
        end else begin
          state_next = GAP;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    sound_next = (state_next == PLAY) ? silence_next : 1'b0;
    busy_next  = (state_next != IDLE);
    done_next  = (state_next == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      melodySelect <= 4'd0;
      noteIndex    <= 5'd0;
      tone         <= SILENCE;
      len_reg      <= 4'd0;
      silence_reg  <= 1'b0;
      beat_cnt     <= 4'd0;
      soundEnable  <= 1'b0;
      busy         <= 1'b0;
      melodyDone   <= 1'b0;
    end else begin
      state        <= state_next;
      melodySelect <= sel_next;
      noteIndex    <= note_next;
      tone         <= tone_next;
      len_reg      <= len_next;
      silence_reg  <= silence_next;
      beat_cnt     <= beat_next;
      soundEnable  <= sound_next;
      busy         <= busy_next;
      melodyDone   <= done_next;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// -----------------------------------------------------------------------------
// tb_melody_sequencer
// Directed bench for melody_sequencer with BEAT_CLKS = 4 and GAP_CLKS = 2.
// A small array ROM answers the sequencer's noteIndex. Inputs are driven and
// outputs sampled 1 time unit after each rising edge; sample k is taken after
// the k-th edge following the edge that accepted startMelody.
// Per note of length L: 1 LOAD clock, 4*L PLAY clocks, 2 GAP clocks.
// -----------------------------------------------------------------------------
module tb_melody_sequencer;
  import audio_pkg::*;

  logic       clk;
  logic       reset;
  logic       startMelody, stopMelody, loopEn;
  logic [3:0] melodyReq;
  logic [3:0] toneIn, lengthIn;
  logic       silenceInN;
  logic [3:0] melodySelect;
  logic [4:0] noteIndex;
  logic [3:0] tone;
  logic       soundEnable, busy, melodyDone;

  logic [3:0] rom_tone [MAX_NOTES];
  logic [3:0] rom_len  [MAX_NOTES];
  logic       rom_sil  [MAX_NOTES];

  assign toneIn     = rom_tone[noteIndex];
  assign lengthIn   = rom_len[noteIndex];
  assign silenceInN = rom_sil[noteIndex];

  int tests = 0;
  int fails = 0;

  logic       tr_snd  [40];
  logic [3:0] tr_tone [40];
  logic       tr_done [40];
  logic       tr_busy [40];
  logic [4:0] tr_idx  [40];

  melody_sequencer #(.BEAT_CLKS(4), .GAP_CLKS(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .startMelody  (startMelody),
    .stopMelody   (stopMelody),
    .loopEn       (loopEn),
    .melodyReq    (melodyReq),
    .toneIn       (toneIn),
    .lengthIn     (lengthIn),
    .silenceInN   (silenceInN),
    .melodySelect (melodySelect),
    .noteIndex    (noteIndex),
    .tone         (tone),
    .soundEnable  (soundEnable),
    .busy         (busy),
    .melodyDone   (melodyDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one clock; returns just after the accepting edge (k = 0).
  task automatic start_melody(input logic [3:0] req);
    step();
    melodyReq   = req;
    startMelody = 1'b1;
    step();
    startMelody = 1'b0;
  endtask

  // Record n samples, k = 0 .. n-1, starting at the current sample point.
  task automatic trace(input int n);
    for (int k = 0; k < n; k++) begin
      if (k > 0) step();
      tr_snd[k]  = soundEnable;
      tr_tone[k] = tone;
      tr_done[k] = melodyDone;
      tr_busy[k] = busy;
      tr_idx[k]  = noteIndex;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic fill_rom_ones();
    for (int i = 0; i < MAX_NOTES; i++) begin
      rom_tone[i] = 4'(i);
      rom_len[i]  = 4'd1;
      rom_sil[i]  = 1'b1;
    end
  endtask

  initial begin
    int cnt7, cnt4, ndone, cyc;
    logic seen_done;

    reset       = 1'b0;
    startMelody = 1'b0;
    stopMelody  = 1'b0;
    loopEn      = 1'b0;
    melodyReq   = 4'd0;
    fill_rom_ones();

    // Reset state, checked before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst_sel",   {28'd0, melodySelect}, 32'd0);
    check("rst_idx",   {27'd0, noteIndex},    32'd0);
    check("rst_tone",  {28'd0, tone},         32'd15);
    check("rst_sound", {31'd0, soundEnable},  32'd0);
    check("rst_busy",  {31'd0, busy},         32'd0);
    check("rst_done",  {31'd0, melodyDone},   32'd0);
    step();
    step();
    reset = 1'b0;

    // Melody {sol len 2, mi len 1, end}.
    rom_tone[0] = NOTE_SOL; rom_len[0] = 4'd2; rom_sil[0] = 1'b1;
    rom_tone[1] = NOTE_MI;  rom_len[1] = 4'd1; rom_sil[1] = 1'b1;
    rom_tone[2] = 4'd0;     rom_len[2] = 4'd0; rom_sil[2] = 1'b1;
    start_melody(4'd3);
    trace(22);
    cnt7 = 0; cnt4 = 0; ndone = 0;
    for (int k = 0; k < 22; k++) begin
      if (tr_snd[k] && tr_tone[k] == 4'd7) cnt7++;
      if (tr_snd[k] && tr_tone[k] == 4'd4) cnt4++;
      if (tr_done[k]) ndone++;
    end
    check("t1_sel",        {28'd0, melodySelect}, 32'd3);
    check("t1_load_quiet", {31'd0, tr_snd[0]},    32'd0);
    check("t1_first_snd",  {31'd0, tr_snd[1]},    32'd1);
    check("t1_sol_clks",   cnt7,                  32'd8);
    check("t1_gap1a",      {31'd0, tr_snd[9]},    32'd0);
    check("t1_gap1b",      {31'd0, tr_snd[10]},   32'd0);
    check("t1_mi_start",   {31'd0, tr_snd[12]},   32'd1);
    check("t1_mi_tone",    {28'd0, tr_tone[12]},  32'd4);
    check("t1_mi_clks",    cnt4,                  32'd4);
    check("t1_gap2",       {31'd0, tr_snd[16]},   32'd0);
    check("t1_done_pos",   {31'd0, tr_done[19]},  32'd1);
    check("t1_done_cnt",   ndone,                 32'd1);
    check("t1_busy_done",  {31'd0, tr_busy[19]},  32'd1);
    check("t1_idle",       {31'd0, tr_busy[20]},  32'd0);

    // Rest of length 3, then an audible note, then end.
    rom_tone[0] = 4'd2; rom_len[0] = 4'd3; rom_sil[0] = 1'b0;
    rom_tone[1] = 4'd5; rom_len[1] = 4'd1; rom_sil[1] = 1'b1;
    rom_tone[2] = 4'd0; rom_len[2] = 4'd0; rom_sil[2] = 1'b1;
    start_melody(4'd1);
    trace(20);
    cyc = 0;
    for (int k = 0; k < 15; k++) if (tr_snd[k]) cyc++;
    check("t2_rest_quiet", cyc,                   32'd0);
    check("t2_rest_busy",  {31'd0, tr_busy[6]},   32'd1);
    check("t2_idx_next",   {27'd0, tr_idx[15]},   32'd1);
    check("t2_next_snd",   {31'd0, tr_snd[16]},   32'd1);
    check("t2_next_tone",  {28'd0, tr_tone[16]},  32'd5);
    wait_idle("t2_idle");

    // 32 notes without an end marker: finish after note 31.
    fill_rom_ones();
    start_melody(4'd2);
    cyc = 0;
    while (!melodyDone && cyc < 400) begin
      step();
      cyc++;
    end
    check("t3_done_cycle", cyc,                  32'd224);
    check("t3_done_idx",   {27'd0, noteIndex},   32'd31);
    step();
    check("t3_idle",       {31'd0, busy},        32'd0);
    check("t3_idx_hold",   {27'd0, noteIndex},   32'd31);

    // Same ROM looping: index wraps to 0 and busy stays high.
    loopEn = 1'b1;
    start_melody(4'd2);
    seen_done = 1'b0;
    for (int k = 1; k < 224; k++) begin
      step();
      seen_done = seen_done | melodyDone;
    end
    check("t3l_idx31",   {27'd0, noteIndex}, 32'd31);
    step();
    check("t3l_wrap",    {27'd0, noteIndex}, 32'd0);
    check("t3l_busy",    {31'd0, busy},      32'd1);
    check("t3l_no_done", {31'd0, seen_done}, 32'd0);
    stopMelody = 1'b1;
    step();
    stopMelody = 1'b0;
    loopEn     = 1'b0;
    check("t3l_stop_done", {31'd0, melodyDone}, 32'd1);
    wait_idle("t3l_idle");

    // Stop in the middle of note 2's PLAY (note 2 plays at k = 15..18).
    start_melody(4'd4);
    for (int k = 1; k <= 15; k++) step();
    check("t4_pre_snd", {31'd0, soundEnable}, 32'd1);
    check("t4_pre_idx", {27'd0, noteIndex},   32'd2);
    stopMelody = 1'b1;
    step();
    stopMelody = 1'b0;
    check("t4_snd_off", {31'd0, soundEnable}, 32'd0);
    check("t4_done",    {31'd0, melodyDone},  32'd1);
    step();
    check("t4_idle",    {31'd0, busy},        32'd0);
    check("t4_done_1c", {31'd0, melodyDone},  32'd0);

    // Start during GAP is ignored; start+stop together ends in DONE.
    start_melody(4'd2);
    for (int k = 1; k <= 5; k++) step();
    melodyReq   = 4'd5;
    startMelody = 1'b1;
    step();
    startMelody = 1'b0;
    check("t5_sel_kept", {28'd0, melodySelect}, 32'd2);
    check("t5_busy",     {31'd0, busy},         32'd1);
    step();
    step();
    startMelody = 1'b1;
    stopMelody  = 1'b1;
    step();
    startMelody = 1'b0;
    stopMelody  = 1'b0;
    check("t5_both_done", {31'd0, melodyDone},  32'd1);
    check("t5_both_snd",  {31'd0, soundEnable}, 32'd0);
    step();
    check("t5_both_idle", {31'd0, busy},        32'd0);
    check("t5_sel_final", {28'd0, melodySelect}, 32'd2);

    // Asynchronous reset mid-PLAY.
    start_melody(4'd9);
    step();
    step();
    check("t6_playing", {31'd0, soundEnable}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_sel",   {28'd0, melodySelect}, 32'd0);
    check("t6_idx",   {27'd0, noteIndex},    32'd0);
    check("t6_tone",  {28'd0, tone},         32'd15);
    check("t6_sound", {31'd0, soundEnable},  32'd0);
    check("t6_busy",  {31'd0, busy},         32'd0);
    check("t6_done",  {31'd0, melodyDone},   32'd0);
    step();
    reset = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      seen_done = seen_done | melodyDone | busy;
    end
    check("t6_quiet_after", {31'd0, seen_done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
